// File: rtl/cic_decimator_mc.sv
// Shared-datapath, time-interleaved N-stage CIC decimator with per-channel integrator/comb state,
// runtime-selectable rate latched at period boundaries, and a registered AXI-stream output.
module cic_decimator_mc #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int RMAX      = 8,
  parameter int M         = 1,
  parameter int N         = 3,
  parameter int REG_WIDTH = WIDTH + $clog2((RMAX * M) ** N),
  parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int RW       = $clog2(RMAX + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     input_tdata,
  input  logic                        input_tvalid,
  output logic                        input_tready,
  output logic signed [REG_WIDTH-1:0] output_tdata,
  output logic [CW-1:0]               output_tdest,
  output logic                        output_tlast,
  output logic                        output_tvalid,
  input  logic                        output_tready,
  input  logic [RW-1:0]               rate
);

  function automatic logic signed [REG_WIDTH-1:0] sext(input logic signed [WIDTH-1:0] x);
    return REG_WIDTH'(x);
  endfunction

  // Clamp the requested rate into 1..RMAX.
  function automatic logic [RW-1:0] eff_rate(input logic [RW-1:0] r);
    if (r == '0)
      return RW'(1);
    else if (r > RW'(RMAX))
      return RW'(RMAX);
    else
      return r;
  endfunction

  logic signed [REG_WIDTH-1:0] integ [CHANNELS][N];
  logic signed [REG_WIDTH-1:0] dly   [CHANNELS][N][M];

  logic [CW-1:0] ch;
  logic [RW-1:0] ph;
  logic [RW-1:0] rate_reg;
  logic [RW-1:0] r_cur;
  logic          last_ch;
  logic          xfer;
  logic          emit;

  logic signed [REG_WIDTH-1:0] int_p0  [N];
  logic signed [REG_WIDTH-1:0] comb_in [N];
  logic signed [REG_WIDTH-1:0] acc_i;
  logic signed [REG_WIDTH-1:0] acc_c;

  assign last_ch      = (ch == CW'(CHANNELS - 1));
  assign input_tready = !((ph == '0) && output_tvalid && !output_tready);
  assign xfer         = input_tvalid && input_tready;
  assign emit         = xfer && (ph == '0);
  // The rate latched on this same transfer must already govern the phase wrap.
  assign r_cur        = ((ch == '0) && (ph == '0)) ? eff_rate(rate) : rate_reg;

  // Stage p0: integrator chain and comb chain for the current channel, in one cycle
  always_comb begin
    acc_i = sext(input_tdata);
    for (int k = 0; k < N; k++) begin
      acc_i     = integ[ch][k] + acc_i;
      int_p0[k] = acc_i;
    end
    acc_c = acc_i;
    for (int k = 0; k < N; k++) begin
      comb_in[k] = acc_c;
      acc_c      = acc_c - dly[ch][k][M-1];
    end
  end

  // Stage p1: state write-back and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < N; k++) begin
          integ[c][k] <= '0;
          for (int m = 0; m < M; m++) dly[c][k][m] <= '0;
        end
      end
      ch            <= '0;
      ph            <= '0;
      rate_reg      <= RW'(1);
      output_tdata  <= '0;
      output_tdest  <= '0;
      output_tlast  <= 1'b0;
      output_tvalid <= 1'b0;
    end else begin
      if (xfer) begin
        for (int k = 0; k < N; k++) integ[ch][k] <= int_p0[k];
        ch <= last_ch ? '0 : ch + 1'b1;
        if ((ch == '0) && (ph == '0)) rate_reg <= eff_rate(rate);
        if (last_ch) ph <= (ph == r_cur - 1'b1) ? '0 : ph + 1'b1;
        if (ph == '0) begin
          for (int k = 0; k < N; k++) begin
            dly[ch][k][0] <= comb_in[k];
            for (int m = 1; m < M; m++) dly[ch][k][m] <= dly[ch][k][m-1];
          end
          output_tdata <= acc_c;
          output_tdest <= ch;
          output_tlast <= last_ch;
        end
      end
      if (emit)
        output_tvalid <= 1'b1;
      else if (output_tready)
        output_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Directed-sequence bench for cic_decimator_mc with randomized data and a reference model based on
// N-fold cumulative sums followed by binomial N-th order differences of the decimated sequence.
module tb_cic_decimator_mc;
  localparam int WIDTH     = 16;
  localparam int CHANNELS  = 2;
  localparam int RMAX      = 8;
  localparam int M         = 1;
  localparam int N         = 3;
  localparam int REG_WIDTH = 25;
  localparam int CW        = 1;
  localparam int RW        = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic signed [WIDTH-1:0]     input_tdata = '0;
  logic                        input_tvalid = 1'b0;
  logic                        input_tready;
  logic signed [REG_WIDTH-1:0] output_tdata;
  logic [CW-1:0]               output_tdest;
  logic                        output_tlast;
  logic                        output_tvalid;
  logic                        output_tready = 1'b1;
  logic [RW-1:0]               rate = 4'd1;

  always #5 clk = ~clk;

  cic_decimator_mc #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .RMAX(RMAX), .M(M), .N(N)
  ) dut (
    .clk(clk), .rst(rst),
    .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tready(input_tready),
    .output_tdata(output_tdata), .output_tdest(output_tdest), .output_tlast(output_tlast),
    .output_tvalid(output_tvalid), .output_tready(output_tready),
    .rate(rate)
  );

  typedef struct {
    logic signed [REG_WIDTH-1:0] d;
    logic [CW-1:0]               dest;
    logic                        last;
  } out_t;

  int     passed = 0;
  int     total  = 0;
  longint cum  [CHANNELS][N];
  longint hist [CHANNELS][$];
  out_t   exp_q[$];
  int     mch, mph, mrate;
  int     n_out;
  bit     imp_mode = 1'b0;
  int     imp_idx;
  logic signed [REG_WIDTH-1:0] last_out [CHANNELS];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  function automatic longint binom(input int n, input int k);
    longint b = 1;
    for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
    return b;
  endfunction

  function automatic longint imp_tab(input int i);
    if (i == 0) return 1;
    if (i == 1) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < N; k++) cum[c][k] = 0;
      hist[c].delete();
    end
    exp_q.delete();
    mch = 0; mph = 0; mrate = 1;
  endtask

  task automatic model_xfer(input logic signed [WIDTH-1:0] x, input int r);
    int     c = mch;
    int     idx;
    longint y;
    longint v;
    out_t   o;
    cum[c][0] += x;
    for (int k = 1; k < N; k++) cum[c][k] += cum[c][k-1];
    if (mch == 0 && mph == 0) mrate = (r == 0) ? 1 : ((r > RMAX) ? RMAX : r);
    if (mph == 0) begin
      hist[c].push_back(cum[c][N-1]);
      y = 0;
      for (int k = 0; k <= N; k++) begin
        idx = hist[c].size() - 1 - k * M;
        if (idx >= 0) y += ((k % 2) ? -1 : 1) * binom(N, k) * hist[c][idx];
      end
      v      = y;
      o.d    = v[REG_WIDTH-1:0];
      o.dest = CW'(c);
      o.last = (c == CHANNELS - 1);
      exp_q.push_back(o);
    end
    if (mch == CHANNELS - 1) mph = (mph == mrate - 1) ? 0 : mph + 1;
    mch = (mch == CHANNELS - 1) ? 0 : mch + 1;
  endtask

  task automatic step(input bit tv, input logic signed [WIDTH-1:0] x, input int r, input bit otr);
    bit mtr;
    @(negedge clk);
    rst           = 1'b0;
    input_tvalid  = tv;
    input_tdata   = x;
    rate          = RW'(r);
    output_tready = otr;
    #1;
    mtr = !(mph == 0 && exp_q.size() > 0 && !otr);
    chk("input_tready", input_tready, mtr);
    chk("output_tvalid", output_tvalid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("output_tdata", output_tdata, exp_q[0].d);
      chk("output_tdest", output_tdest, exp_q[0].dest);
      chk("output_tlast", output_tlast, exp_q[0].last);
      if (otr) begin
        if (imp_mode) begin
          if (exp_q[0].dest == 0) begin
            chk("impulse_ch0", output_tdata, imp_tab(imp_idx));
            imp_idx++;
          end else begin
            chk("impulse_ch1", output_tdata, 0);
          end
        end
        last_out[exp_q[0].dest] = output_tdata;
        n_out++;
        void'(exp_q.pop_front());
      end
    end
    if (tv && mtr) model_xfer(x, r);
  endtask

  task automatic do_reset(input bit otr);
    @(negedge clk);
    rst           = 1'b1;
    input_tvalid  = 1'b0;
    output_tready = otr;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tvalid", output_tvalid, 0);
    chk("rst_tdata", output_tdata, 0);
    chk("rst_tdest", output_tdest, 0);
    chk("rst_tlast", output_tlast, 0);
    chk("rst_input_tready", input_tready, 1);
    model_reset();
  endtask

  function automatic logic signed [WIDTH-1:0] rnd();
    return WIDTH'($urandom);
  endfunction

  initial begin
    int guard;
    model_reset();
    do_reset(1'b1);

    // Constant inputs, R=4: steady outputs 64 / -128, one output per 4 frames
    n_out = 0;
    for (int f = 0; f < 64; f++) begin
      step(1'b1, 16'sd1, 4, 1'b1);
      step(1'b1, -16'sd2, 4, 1'b1);
    end
    step(1'b0, '0, 4, 1'b1);
    chk("const_ch0", last_out[0], 64);
    chk("const_ch1", last_out[1], -128);
    chk("const_out_count", n_out, 32);

    // Impulse on ch0, R=2
    do_reset(1'b1);
    imp_mode = 1'b1;
    imp_idx  = 0;
    step(1'b1, 16'sd1, 2, 1'b1);
    step(1'b1, 16'sd0, 2, 1'b1);
    for (int f = 0; f < 20; f++) begin
      step(1'b1, 16'sd0, 2, 1'b1);
      step(1'b1, 16'sd0, 2, 1'b1);
    end
    step(1'b0, '0, 2, 1'b1);
    imp_mode = 1'b0;
    chk("impulse_count", imp_idx, 11);

    // Random data with gaps, then a 20-cycle output stall, then random backpressure
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) step(1'($urandom), rnd(), 3, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, rnd(), 3, 1'b0);
    for (int i = 0; i < 60; i++) step(1'($urandom), rnd(), 3, 1'($urandom));

    // Rate change 4 -> 2 mid-period, then rate=0 (R=1) and rate=15 (R=8)
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, rnd(), 4, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, rnd(), 2, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, rnd(), 0, 1'b1);
    for (int i = 0; i < 48; i++) step(1'b1, rnd(), 15, 1'($urandom));

    // Reset mid-frame while the output is stalled
    guard = 0;
    while (!(exp_q.size() > 0 && mch == 1) && guard < 50) begin
      step(1'b1, rnd(), 2, 1'b0);
      guard++;
    end
    chk("stall_reached", guard < 50, 1);
    do_reset(1'b0);
    step(1'b1, 16'sd7, 2, 1'b1);
    step(1'b1, 16'sd0, 2, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, rnd(), 2, 1'b1);

    // Full-scale negative input, R=8
    do_reset(1'b1);
    for (int f = 0; f < 40; f++) begin
      step(1'b1, -16'sd32768, 15, 1'b1);
      step(1'b1, -16'sd32768, 15, 1'b1);
    end
    step(1'b0, '0, 15, 1'b1);
    chk("fullscale_ch0", last_out[0], -16777216);
    chk("fullscale_ch1", last_out[1], -16777216);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cic_decimator_mc.md
# cic_decimator_mc

Multi-channel, time-interleaved cascaded integrator-comb decimator with runtime-selectable rate, a registered AXI-stream output that tolerates backpressure, and per-sample channel tagging. It sits after the ADC/NCO mixer stage and before the compensating FIR. It replaces per-channel decimator instances with one shared datapath that holds independent integrator and comb state per channel.

## Interface
- WIDTH, 16: input sample width, two's complement
- CHANNELS, 2: interleaved channel count (>=1)
- RMAX, 8: maximum decimation rate
- M, 1: comb differential delay
- N, 3: number of integrator and comb stages
- REG_WIDTH, WIDTH+$clog2((RMAX*M)**N): internal and output width (25 at defaults)
- CW, $clog2(CHANNELS) (min 1): channel index width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- input_tdata  in  WIDTH  sample of the current channel
- input_tvalid  in  1  sample valid
- input_tready  out  1  sample accepted when tvalid&tready
- output_tdata  out  REG_WIDTH  decimated sample, sign-extended full precision
- output_tdest  out  CW  channel index of output_tdata
- output_tlast  out  1  high on the output of channel CHANNELS-1
- output_tvalid  out  1  output register holds data
- output_tready  in  1  downstream accept
- rate  in  $clog2(RMAX+1)  requested decimation rate

## Operation
- Input samples arrive strictly in channel order 0,1,...,CHANNELS-1 and repeat. An internal channel counter ch (0..CHANNELS-1) advances on each input transfer and wraps after CHANNELS-1.
- Phase counter ph (0..R-1) is shared by all channels. It advances when channel CHANNELS-1 transfers. It wraps to 0 when ph==R-1.
- Effective rate R is latched into rate_reg on the input transfer where ch==0 and ph==0. R = 1 if rate==0; R = RMAX if rate>RMAX; otherwise R = rate. A rate change therefore takes effect only at a period boundary and never splits channels.
- Integrators: every input transfer on channel c updates the chain in one cycle. i0 = int[c][0] + sext(x); ik = int[c][k] + i(k-1); all N values are stored back. Arithmetic is modulo 2^REG_WIDTH, and wrap is intended.
- Comb: an input transfer with ph==0 is an emit transfer. On an emit transfer, c0 = i(N-1) (the new value) minus dly[c][0][M-1]; ck = c(k-1) - dly[c][k][M-1]. Each dly[c][k] line shifts in its stage input. cN-1 is loaded into the output register with tdest=c and tlast=(c==CHANNELS-1). Non-emit transfers leave comb state untouched.
- Emitted samples are the input samples at phase 0 of each period, matching the single-channel decimator's phase convention.
- input_tready = !(ph==0 && output_tvalid && !output_tready). Non-emit samples are never stalled by the output.
- output_tvalid sets on an emit transfer. It clears on an output transfer with no simultaneous emit. A simultaneous output transfer and emit reloads the register and keeps tvalid high.
- Output data, tdest and tlast are stable while tvalid && !tready.

## Timing
- Latency from the emit input transfer to output_tvalid is 1 cycle (registered).
- Throughput is 1 input sample per cycle with output_tready held high.
- Reset (any cycle, including mid-frame or while output is stalled) clears everything: all integrator, comb and delay state; ch=0; ph=0; rate_reg=1. Outputs go to output_tvalid=0, output_tdata=0, output_tdest=0, output_tlast=0. input_tready is 1 in the first cycle after reset.
- There is no state change in cycles without an input transfer, apart from the output handshake.

## Test plan
- CHANNELS=2, R=4, N=3, M=1, constant ch0=1 and ch1=-2 with tready=1. After settling, every ch0 output = 64 (tdest=0, tlast=0) and every ch1 output = -128 (tdest=1, tlast=1). There is exactly 1 output per 4 input frames.
- Impulse of 1 on ch0 at reset, zeros elsewhere, R=2. ch0 output sequence equals the CIC impulse response decimated by 2. ch1 outputs are all 0, which shows channel independence.
- output_tready=0 for 20 cycles under continuous input. input_tready drops only at the next ph==0 sample. output_tdata, tdest and tlast are held constant. No sample is lost or duplicated after release.
- Change rate from 4 to 2 mid-period. The current period completes at R=4 and the next uses R=2. rate=0 gives R=1; rate=15 gives R=8.
- Assert rst mid-frame while the output is stalled. The next cycle shows all outputs at 0, input_tready=1, and the next input is treated as ch0, ph0.
- Full-scale input -32768 on all channels, R=8. Output = -32768*512 = -16777216, which fits REG_WIDTH=25 exactly.
